// File: rtl/processor_alu_issue.sv
// Operand-issue stage in front of the 32-bit ALU: reads operands from an
// internal register file, pulses the ALU capture enable, then writes the
// ALU's registered result back. One instruction every three cycles.
module processor_alu_issue #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_instr_valid,
    output logic          o_instr_ready,
    input  logic [2:0]    i_instr_op,
    input  logic [AW-1:0] i_instr_rs,
    input  logic [AW-1:0] i_instr_rt,
    input  logic [AW-1:0] i_instr_rd,
    input  logic [15:0]   i_instr_imm,
    input  logic          i_instr_use_imm,
    output logic [DW-1:0] o_alu_in1,
    output logic [DW-1:0] o_alu_in2,
    output logic [2:0]    o_alu_op,
    output logic          o_alu_wren,
    input  logic [DW-1:0] i_alu_out,
    output logic          o_wb_done,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_dbg_data
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWb    = 2'd2
    } state_e;

    state_e        r_state;
    logic [DW-1:0] r_alu_in1;
    logic [DW-1:0] r_alu_in2;
    logic [2:0]    r_alu_op;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_rf [NREGS];

    logic [DW-1:0] w_rs_data;
    logic [DW-1:0] w_rt_data;
    logic [DW-1:0] w_imm_ext;
    logic [DW-1:0] w_in2;

    // Register-file read ports; register 0 is hard-wired to zero.
    always_comb begin
        w_rs_data  = (i_instr_rs == '0) ? '0 : r_rf[i_instr_rs];
        w_rt_data  = (i_instr_rt == '0) ? '0 : r_rf[i_instr_rt];
        w_imm_ext  = {{(DW-16){i_instr_imm[15]}}, i_instr_imm};
        w_in2      = i_instr_use_imm ? w_imm_ext : w_rt_data;
        o_dbg_data = (i_dbg_addr == '0) ? '0 : r_rf[i_dbg_addr];
    end

    // Status and ALU-facing outputs are decodes of the state register.
    always_comb begin
        o_instr_ready = (r_state == StIdle);
        o_alu_wren    = (r_state == StIssue);
        o_wb_done     = (r_state == StWb);
        o_alu_in1     = r_alu_in1;
        o_alu_in2     = r_alu_in2;
        o_alu_op      = r_alu_op;
    end

    // Sequencer: accept in IDLE, pulse ALU in ISSUE, write back in WB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_alu_in1 <= '0;
            r_alu_in2 <= '0;
            r_alu_op  <= '0;
            r_rd      <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_instr_valid) begin
                        r_alu_in1 <= w_rs_data;
                        r_alu_in2 <= w_in2;
                        r_alu_op  <= i_instr_op;
                        r_rd      <= i_instr_rd;
                        r_state   <= StIssue;
                    end
                end
                StIssue: begin
                    r_state <= StWb;
                end
                StWb: begin
                    // Write lands before the next accept, so no forwarding is needed.
                    if (r_rd != '0) begin
                        r_rf[r_rd] <= i_alu_out;
                    end
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_processor_alu_issue.sv
// Bench for processor_alu_issue: a behavioural ALU closes the loop, a
// scoreboard checks the operands presented on each ALU capture pulse, and
// directed sequences check timing, writeback and reset behaviour.
module tb_processor_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rs;
    logic [2:0]  instr_rt;
    logic [2:0]  instr_rd;
    logic [15:0] instr_imm;
    logic        instr_use_imm;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [2:0]  alu_op;
    logic        alu_wren;
    logic [31:0] alu_out;
    logic        wb_done;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    // Expected {op, in1, in2} for each ALU capture pulse.
    logic [66:0] exp_q[$];

    processor_alu_issue #(
        .NREGS(8),
        .AW   (3),
        .DW   (32)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_instr_valid  (instr_valid),
        .o_instr_ready  (instr_ready),
        .i_instr_op     (instr_op),
        .i_instr_rs     (instr_rs),
        .i_instr_rt     (instr_rt),
        .i_instr_rd     (instr_rd),
        .i_instr_imm    (instr_imm),
        .i_instr_use_imm(instr_use_imm),
        .o_alu_in1      (alu_in1),
        .o_alu_in2      (alu_in2),
        .o_alu_op       (alu_op),
        .o_alu_wren     (alu_wren),
        .i_alu_out      (alu_out),
        .o_wb_done      (wb_done),
        .i_dbg_addr     (dbg_addr),
        .o_dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: registered result captured on the wren edge.
    always @(posedge clk) begin
        if (alu_wren) begin
            case (alu_op)
                3'd1:    alu_out <= alu_in1 - alu_in2;
                3'd2:    alu_out <= alu_in1 & alu_in2;
                3'd3:    alu_out <= alu_in1 | alu_in2;
                3'd4:    alu_out <= ~alu_in1;
                default: alu_out <= alu_in1 + alu_in2;
            endcase
        end
    end

    // Monitor: every capture pulse must match the oldest expected operand set.
    always @(negedge clk) begin
        logic [66:0] e;
        if (rst_n && alu_wren) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got op=%0d in1=%h in2=%h, expected no issue",
                         alu_op, alu_in1, alu_in2);
            end else begin
                e = exp_q.pop_front();
                if ({alu_op, alu_in1, alu_in2} !== e) begin
                    bad++;
                    $display("FAIL issue_operands: got op=%0d in1=%h in2=%h, expected op=%0d in1=%h in2=%h",
                             alu_op, alu_in1, alu_in2, e[66:64], e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_dbg(input logic [2:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check($sformatf("dbg_r%0d", addr), dbg_data, exp);
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input logic [15:0] imm, input logic use_imm);
        instr_op      = op;
        instr_rs      = rs;
        instr_rt      = rt;
        instr_rd      = rd;
        instr_imm     = imm;
        instr_use_imm = use_imm;
    endtask

    // One full instruction: accept, check the 3-cycle shape, check the result.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                             input logic [2:0] rd, input logic [15:0] imm, input logic use_imm,
                             input logic [31:0] e1, input logic [31:0] e2,
                             input logic [31:0] e_rd);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", {31'd0, instr_ready}, 32'd1);
        drive(op, rs, rt, rd, imm, use_imm);
        instr_valid = 1'b1;
        exp_q.push_back({op, e1, e2});
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("issue_wren",  {31'd0, alu_wren},    32'd1);
        check("issue_ready", {31'd0, instr_ready}, 32'd0);
        check("issue_wb",    {31'd0, wb_done},     32'd0);
        @(posedge clk);
        #1;
        check("wb_wren",  {31'd0, alu_wren},    32'd0);
        check("wb_done",  {31'd0, wb_done},     32'd1);
        check("wb_ready", {31'd0, instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("post_wb_done",  {31'd0, wb_done},     32'd0);
        check("post_wb_ready", {31'd0, instr_ready}, 32'd1);
        check_dbg(rd, e_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  h_op  [4];
        logic [2:0]  h_rs  [4];
        logic [2:0]  h_rt  [4];
        logic [2:0]  h_rd  [4];
        logic [15:0] h_imm [4];
        logic        h_ui  [4];
        logic [31:0] h_e1  [4];
        logic [31:0] h_e2  [4];
        logic [31:0] rnd;
        int          acc;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        alu_out     = '0;
        dbg_addr    = '0;
        drive(3'd0, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, instr_ready}, 32'd1);
        check("reset_wren",  {31'd0, alu_wren},    32'd0);
        check("reset_wb",    {31'd0, wb_done},     32'd0);
        check("reset_in1",   alu_in1,              32'd0);
        for (int a = 0; a < 8; a++) check_dbg(a[2:0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Immediate adds, including a negative immediate.
        run_instr(3'd0, 3'd0, 3'd0, 3'd1, 16'h0005, 1'b1, 32'd0, 32'h5,        32'h5);
        run_instr(3'd0, 3'd0, 3'd0, 3'd2, 16'hFFFF, 1'b1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        // Dependent chain issued as soon as ready returns.
        run_instr(3'd1, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b0, 32'h5, 32'hFFFFFFFF, 32'h6);
        run_instr(3'd2, 3'd3, 3'd0, 3'd5, 16'h0004, 1'b1, 32'h6, 32'h4,        32'h4);
        // Write to r0 is dropped; a following read of r0 sees zero.
        run_instr(3'd0, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b1, 32'h5, 32'h5,        32'h0);
        run_instr(3'd3, 3'd0, 3'd1, 3'd6, 16'h0000, 1'b0, 32'h0, 32'h5,        32'h5);

        // Valid held high: one accept every 3 cycles, mid-flight inputs ignored.
        h_op[0] = 3'd4; h_rs[0] = 3'd6; h_rt[0] = 3'd1; h_rd[0] = 3'd7;
        h_imm[0] = 16'h0000; h_ui[0] = 1'b0; h_e1[0] = 32'h5; h_e2[0] = 32'h5;
        h_op[1] = 3'd2; h_rs[1] = 3'd7; h_rt[1] = 3'd0; h_rd[1] = 3'd2;
        h_imm[1] = 16'h00F0; h_ui[1] = 1'b1; h_e1[1] = 32'hFFFFFFFA; h_e2[1] = 32'hF0;
        h_op[2] = 3'd5; h_rs[2] = 3'd2; h_rt[2] = 3'd5; h_rd[2] = 3'd3;
        h_imm[2] = 16'h0000; h_ui[2] = 1'b0; h_e1[2] = 32'hF0; h_e2[2] = 32'h4;
        h_op[3] = 3'd1; h_rs[3] = 3'd3; h_rt[3] = 3'd0; h_rd[3] = 3'd1;
        h_imm[3] = 16'h8000; h_ui[3] = 1'b1; h_e1[3] = 32'hF4; h_e2[3] = 32'hFFFF8000;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("hold_ready_c%0d", k), {31'd0, instr_ready},
                  (k % 3 == 0) ? 32'd1 : 32'd0);
            if (instr_ready && acc < 4) begin
                drive(h_op[acc], h_rs[acc], h_rt[acc], h_rd[acc], h_imm[acc], h_ui[acc]);
                exp_q.push_back({h_op[acc], h_e1[acc], h_e2[acc]});
                acc++;
            end else begin
                rnd = $urandom;
                drive(rnd[2:0], rnd[5:3], rnd[8:6], rnd[11:9], rnd[27:12], rnd[28]);
            end
            instr_valid = 1'b1;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        check("hold_accepts", acc, 32'd4);
        @(posedge clk);
        #1;
        check_dbg(3'd7, 32'hFFFFFFFA);
        check_dbg(3'd2, 32'h000000F0);
        check_dbg(3'd3, 32'h000000F4);
        check_dbg(3'd1, 32'h000080F4);

        // Reset during WB aborts the write immediately.
        @(negedge clk);
        drive(3'd0, 3'd0, 3'd0, 3'd4, 16'h1234, 1'b1);
        instr_valid = 1'b1;
        exp_q.push_back({3'd0, 32'd0, 32'h1234});
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_wb", {31'd0, wb_done}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_async_wb",    {31'd0, wb_done},     32'd0);
        check("rst_async_wren",  {31'd0, alu_wren},    32'd0);
        check("rst_async_in2",   alu_in2,              32'd0);
        check("rst_async_op",    {29'd0, alu_op},      32'd0);
        check_dbg(3'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_dbg(3'd4, 32'd0);
        check("rst_after_ready", {31'd0, instr_ready}, 32'd1);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/processor_alu_issue.md
Name: processor_alu_issue

Overview:
Operand-issue stage sitting directly upstream of the 32-bit processor ALU. Accepts one decoded instruction per valid/ready handshake and reads operands from an internal 8x32 register file. Drives the ALU operands, opcode and one-cycle write-enable, then writes the ALU's registered result back to the destination register. A three-state FSM sequences each instruction over 3 cycles.

Parameters:
NREGS, 8, number of architectural registers (register 0 reads as zero, writes ignored)
AW, 3, register address width (log2 NREGS)
DW, 32, data width (must match the ALU)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
instr_valid  in  1  decoded instruction present
instr_ready  out  1  stage can accept (high only in IDLE)
instr_op  in  3  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 not
instr_rs  in  AW  source register 1
instr_rt  in  AW  source register 2
instr_rd  in  AW  destination register
instr_imm  in  16  immediate
instr_use_imm  in  1  1: in2 = sign-extended imm; 0: in2 = rf[rt]
alu_in1  out  DW  ALU operand 1 (registered)
alu_in2  out  DW  ALU operand 2 (registered)
alu_op  out  3  ALU opcode (registered)
alu_wren  out  1  ALU capture enable, one-cycle pulse
alu_out  in  DW  ALU registered result
wb_done  out  1  high during the writeback cycle
dbg_addr  in  AW  debug read address
dbg_data  out  DW  rf[dbg_addr], combinational, 0 for address 0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; alu_in1=alu_in2=0; alu_op=0; alu_wren=0; all rf entries=0. instr_ready=1 and wb_done=0 once reset is applied.
- States: IDLE, ISSUE, WB. instr_ready = (state==IDLE). wb_done = (state==WB). alu_wren = (state==ISSUE).
- IDLE: on a posedge with instr_valid=1, latch alu_in1=rf[rs], alu_in2 = use_imm ? {{16{imm[15]}},imm} : rf[rt], alu_op=instr_op, capture rd, then go to ISSUE. If instr_valid=0, stay in IDLE and hold all registers.
- ISSUE: lasts exactly one cycle with alu_wren=1. The ALU captures its result on the closing edge. Then go to WB.
- WB: alu_out is valid. On the closing edge write rf[rd]=alu_out, unless rd==0 (write suppressed). Then go to IDLE.
- Latency: handshake edge T; ISSUE spans T..T+1; WB spans T+1..T+2; register updated at edge T+2; next accept possible at edge T+3. Throughput is 1 instruction per 3 cycles.
- Hazards: the write completes before the next operand read, so no forwarding or stall logic is needed. A back-to-back dependent instruction reads the new value.
- Register 0: reads return 0 on both operand paths and dbg_data, whatever was written.
- Opcodes 5-7 pass through unchanged; the ALU treats them as add. For op 4, alu_in2 is still driven per use_imm.
- Operand registers hold their last value outside IDLE-accept edges.
- Reset mid-instruction, in ISSUE or WB: abort immediately, no register write, state=IDLE, rf cleared.
- Inputs are only sampled in IDLE. Changes to instr_* in ISSUE or WB have no effect.

Test Plan:
- Reset then dbg sweep: every dbg_addr -> dbg_data=0; instr_ready=1, alu_wren=0, wb_done=0.
- Immediate add r1=r0+imm 0x0005, then r2=r0+imm 0xFFFF (sign-extended): alu_wren is a single-cycle pulse one cycle after accept; dbg r1=0x00000005 and r2=0xFFFFFFFF three edges after each accept.
- Dependent chain: sub r3=r1-r2 issued the cycle instr_ready reasserts -> alu_in1=5, alu_in2=0xFFFFFFFF, r3=0x00000006; an and with r3 follows correctly with no stall beyond 3 cycles.
- Write to r0: add rd=0 of 5+5 -> wb_done pulses, dbg r0 stays 0, and a following read of rs=0 gives alu_in1=0.
- Handshake hold: instr_valid held high continuously with 4 instructions -> exactly one accept every 3 cycles; instr_ready low in ISSUE and WB; inputs changed mid-flight are ignored.
- Reset asserted during WB of r4=0x1234 -> r4 stays 0, state IDLE, alu_wren=0, outputs zero immediately (asynchronously).
